sseg_scan_display: RTL and testbench

- Parametrised multiplexed seven-segment driver that replaces the fixed 3-digit, 9-bit address display.
- Accepts a DATA_WIDTH-bit value on a load strobe and converts it to decimal BCD (sequential double-dabble) or hex (direct nibbles).
- Latches the result into a display register and time-multiplexes DIGITS digit enables at a prescaled scan rate.
- Adds leading-zero blanking, per-digit decimal points, an overflow flag and selectable output polarity. Sits between the ROM reader address/data path and the board's LED digits.

---
 rtl/sseg_pkg.sv | 56 +++++
 rtl/bin2bcd_seq.sv | 58 +++++
 rtl/sseg_scan_display.sv | 154 +++++++++++++++
 tb/tb_sseg_scan_display.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed seven-segment display: segment
// patterns, converter state encoding and sizing helpers.
package sseg_pkg;

    // Segment order {a,b,c,d,e,f,g}, bit 6 = a, 1 = lit.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

    // ceil(width * log10(2)) in fixed point: decimal digits needed for 2^width-1.
    function automatic int bcd_nibbles(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3-then-shift step per clock, WIDTH steps
// per conversion. done flags the final step; bcd is complete the cycle after.
module bin2bcd_seq #(
    parameter int WIDTH = 16,
    parameter int NB    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  din,
    output logic              busy,
    output logic              done,
    output logic [4*NB-1:0]   bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] bin_q;
    logic [4*NB-1:0]  bcd_q;
    logic [4*NB-1:0]  bcd_adj;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    always_comb begin
        // NOTE: default assignment first so no path leaves bcd_adj unassigned (no latch).
        bcd_adj = bcd_q;
        for (int i = 0; i < NB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            bin_q  <= din;
            bcd_q  <= '0;
            cnt_q  <= CNT_W'(WIDTH);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            bcd_q <= {bcd_adj[4*NB-2:0], bin_q[WIDTH-1]};
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
                busy_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CNT_W'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/sseg_scan_display.sv
// Multiplexed seven-segment driver: binary-to-BCD or hex load into a display
// register, leading-zero blanking, per-digit dp and prescaled digit scanning.
module sseg_scan_display
    import sseg_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int DIGITS         = 5,
    parameter int PRESCALE       = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic                  busy,
    output logic                  overflow,
    output logic [7:0]            sseg,
    output logic [DIGITS-1:0]     digits
);

    localparam int NB     = bcd_nibbles(DATA_WIDTH);
    localparam int DISP_W = 4 * DIGITS;
    localparam int BCD_W  = 4 * NB;
    localparam int EXT_W  = DATA_WIDTH + BCD_W + DISP_W;
    localparam int PS_W   = $clog2(PRESCALE);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    conv_state_e       state_q;
    logic              busy_q;
    logic              ovf_q;
    logic [DISP_W-1:0] disp_q;
    logic [PS_W-1:0]   ps_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        sseg_q;
    logic [DIGITS-1:0] digits_q;

    logic              conv_start;
    logic              conv_busy;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;

    // Zero-extend both sources so any nibble beyond the display can be tested.
    logic [EXT_W-1:0]  value_ext;
    logic [EXT_W-1:0]  bcd_ext;
    assign value_ext = EXT_W'(value);
    assign bcd_ext   = EXT_W'(conv_bcd);

    assign conv_start = (state_q == ST_IDLE) && load && !hex_mode && !conv_busy;

    bin2bcd_seq #(
        .WIDTH (DATA_WIDTH),
        .NB    (NB)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .din   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        // NOTE: the display register is a handful of flops, not a RAM, so it is reset like any state.
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        if (hex_mode) begin
                            disp_q <= value_ext[DISP_W-1:0];
                            ovf_q  <= |(value_ext >> DISP_W);
                        end else begin
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (conv_done)
                        state_q <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    disp_q  <= bcd_ext[DISP_W-1:0];
                    ovf_q   <= |(bcd_ext >> DISP_W);
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [IDX_W-1:0]  nidx;
    logic [DIGITS-1:0] lz_mask;
    logic              all_zero;
    logic [3:0]        nib_sel;
    logic              blank_sel;
    logic [7:0]        seg_raw;
    logic [DIGITS-1:0] dig_raw;

    assign nidx = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    // lz_mask[i]: every nibble from i up to the top digit is zero.
    always_comb begin
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero & (disp_q[4*i +: 4] == 4'd0);
            lz_mask[i] = all_zero;
        end
    end

    assign nib_sel   = disp_q[int'(nidx)*4 +: 4];
    assign blank_sel = blank_lz && (nidx != '0) && lz_mask[nidx];
    assign seg_raw   = {dp_mask[nidx], blank_sel ? SEG_BLANK : seg_decode(nib_sel)};
    assign dig_raw   = DIGITS'(1) << nidx;

    // digits and sseg load together on the prescaler wrap so they never disagree.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ps_q     <= '0;
            idx_q    <= IDX_W'(DIGITS - 1);
            sseg_q   <= SEG_INV;
            digits_q <= DIG_INV;
        end else if (ps_q == PS_W'(PRESCALE - 1)) begin
            ps_q     <= '0;
            idx_q    <= nidx;
            sseg_q   <= seg_raw ^ SEG_INV;
            digits_q <= dig_raw ^ DIG_INV;
        end else begin
            ps_q <= ps_q + PS_W'(1);
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign sseg     = sseg_q;
    assign digits   = digits_q;

endmodule

// File: tb/tb_sseg_scan_display.sv
// Self-checking bench: two display instances (5 and 4 digits) share stimulus;
// expected digit patterns are queued at load time and compared as slots scan.
`timescale 1ns/1ps
module tb_sseg_scan_display;

    localparam int W  = 16;
    localparam int P5 = 4;
    localparam int P4 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        hex_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic [4:0]  dp_mask = '0;
    logic [3:0]  dp_mask4 = '0;

    logic        busy5, ovf5, busy4, ovf4;
    logic [7:0]  sseg5, sseg4;
    logic [4:0]  digits5;
    logic [3:0]  digits4;

    always #5 clk = ~clk;

    sseg_scan_display #(
        .DATA_WIDTH(W), .DIGITS(5), .PRESCALE(P5), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask), .busy(busy5), .overflow(ovf5),
        .sseg(sseg5), .digits(digits5)
    );

    sseg_scan_display #(
        .DATA_WIDTH(W), .DIGITS(4), .PRESCALE(P4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut4 (
        .clk(clk), .reset(reset), .value(value), .load(load), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask4), .busy(busy4), .overflow(ovf4),
        .sseg(sseg4), .digits(digits4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         sel;
        int         idx;
        logic [7:0] seg;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    function automatic logic [31:0] dec_nibs(input int v, input int nd);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] hex_nibs(input int v, input int nd);
        logic [31:0] r = '0;
        for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v >> (4*i)) & 15);
        return r;
    endfunction

    // Queue the expected active-low pattern of every digit of one instance.
    task automatic push_display(input int sel, input int nd, input logic [31:0] nibs, input string tag);
        exp_t        e;
        logic [4:0]  dpm;
        logic [31:0] upper;
        logic [6:0]  seg7;
        dpm = (sel == 0) ? dp_mask : {1'b0, dp_mask4};
        for (int i = 0; i < nd; i++) begin
            upper = nibs >> (4*i);
            seg7  = (blank_lz && i != 0 && upper == 0) ? 7'h00 : seg_of(nibs[4*i +: 4]);
            e.sel = sel;
            e.idx = i;
            e.seg = ~{dpm[i], seg7};
            e.tag = $sformatf("%s_u%0d_d%0d", tag, sel, i);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain_scoreboard();
        exp_t       e;
        logic       found;
        logic [4:0] pat5;
        logic [3:0] pat4;
        while (sb_q.size() > 0) begin
            e     = sb_q.pop_front();
            pat5  = ~(5'd1 << e.idx);
            pat4  = ~(4'd1 << e.idx);
            found = 1'b0;
            for (int k = 0; k < 200 && !found; k++) begin
                @(negedge clk);
                found = (e.sel == 0) ? (digits5 == pat5) : (digits4 == pat4);
            end
            check({e.tag, "_slot"}, 32'(found), 32'd1);
            if (found) check(e.tag, (e.sel == 0) ? sseg5 : sseg4, e.seg);
        end
    endtask

    task automatic load_value(input logic [15:0] v, input logic hx);
        @(negedge clk);
        value    = v;
        hex_mode = hx;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy5 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   n;
        logic saw;
        logic found;
        logic [4:0] prev;

        // Reset state and first scan wrap.
        repeat (3) @(posedge clk);
        #1;
        check("rst_sseg5", sseg5, 8'hFF);
        check("rst_digits5", digits5, 5'h1F);
        check("rst_busy5", busy5, 1'b0);
        check("rst_ovf5", ovf5, 1'b0);
        check("rst_digits4", digits4, 4'hF);
        check("rst_sseg4", sseg4, 8'hFF);
        @(negedge clk);
        reset = 1'b1;
        repeat (P4) @(posedge clk);
        #1;
        check("prewrap_digits5", digits5, 5'h1F);
        check("wrap_digits4", digits4, 4'hE);
        @(posedge clk);
        #1;
        check("wrap_digits5", digits5, 5'h1E);
        check("wrap_sseg5", sseg5, 8'h81);

        // Decimal 1234 with leading-zero blanking.
        blank_lz = 1'b1;
        load_value(16'd1234, 1'b0);
        push_display(0, 5, dec_nibs(1234, 5), "dec1234");
        push_display(1, 4, dec_nibs(1234, 4), "dec1234");
        check("busy_rise", busy5, 1'b1);
        wait_idle(n);
        check("busy_len", n, 17);
        check("ovf5_1234", ovf5, 1'b0);
        check("ovf4_1234", ovf4, 1'b0);
        drain_scoreboard();

        // Hex path: immediate write, busy never rises.
        load_value(16'hBEEF, 1'b1);
        push_display(0, 5, hex_nibs(16'hBEEF, 5), "hexbeef");
        push_display(1, 4, hex_nibs(16'hBEEF, 4), "hexbeef");
        saw = busy5 | busy4;
        repeat (20) begin
            @(negedge clk);
            saw = saw | busy5 | busy4;
        end
        check("hex_busy_never", saw, 1'b0);
        check("hex_ovf4", ovf4, 1'b0);
        drain_scoreboard();

        // Load during conversion is dropped.
        load_value(16'd1234, 1'b0);
        push_display(0, 5, dec_nibs(1234, 5), "drop");
        push_display(1, 4, dec_nibs(1234, 4), "drop");
        load_value(16'd9999, 1'b0);
        wait_idle(n);
        check("drop_busy_len", n, 15);
        drain_scoreboard();

        // 65535 overflows four digits but fits five.
        load_value(16'd65535, 1'b0);
        push_display(0, 5, dec_nibs(65535, 5), "max");
        push_display(1, 4, dec_nibs(65535, 4), "max");
        wait_idle(n);
        check("max_busy_len", n, 17);
        check("max_ovf4", ovf4, 1'b1);
        check("max_ovf5", ovf5, 1'b0);
        drain_scoreboard();

        // Reset mid-conversion abandons it with no commit.
        load_value(16'd5678, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_busy5", busy5, 1'b0);
        check("midrst_ovf4", ovf4, 1'b0);
        push_display(0, 5, 32'h0, "midrst");
        push_display(1, 4, 32'h0, "midrst");
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            saw = saw | busy5 | busy4;
        end
        check("midrst_busy_quiet", saw, 1'b0);
        drain_scoreboard();

        // 42 without blanking shows leading zeros and clears overflow.
        blank_lz = 1'b0;
        load_value(16'd42, 1'b0);
        push_display(0, 5, dec_nibs(42, 5), "dec42");
        push_display(1, 4, dec_nibs(42, 4), "dec42");
        wait_idle(n);
        check("dec42_ovf4", ovf4, 1'b0);
        drain_scoreboard();

        // Decimal points follow the mask; scan period is DIGITS*PRESCALE.
        dp_mask  = 5'b00100;
        dp_mask4 = 4'b0010;
        push_display(0, 5, dec_nibs(42, 5), "dp");
        push_display(1, 4, dec_nibs(42, 4), "dp");
        drain_scoreboard();
        prev  = digits5;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            found = (digits5 == 5'h1E) && (prev != 5'h1E);
            prev  = digits5;
        end
        check("period_sync", 32'(found), 32'd1);
        n     = 0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            n++;
            found = (digits5 == 5'h1E) && (prev != 5'h1E);
            prev  = digits5;
        end
        check("scan_period", n, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
